// File: rtl/gf_inv_seq.sv
// Sequential GF(2^8) inverter: computes a^254 by square-and-multiply on one shared multiplier.
// Valid/ready handshake on both sides; one operand in flight at a time.
module gf_inv_seq #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StSqr, StMul, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] opnd_q, opnd_d;
    logic [2:0] step_q, step_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] mul_b;
    logic [7:0] mult;

    // Shift-and-add multiply, reducing by x^8 + POLY after every shift.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? POLY : 8'h00);
        end
        return p;
    endfunction

    assign mul_b = (state_q == StMul) ? opnd_q : acc_q;
    assign mult  = gf_mul(acc_q, mul_b);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        step_d      = step_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    opnd_d  = in_data;
                    step_d  = 3'd6;
                    state_d = StSqr;
                end
            end
            StSqr: begin
                acc_d = mult;
                if (step_q != 3'd0) begin
                    state_d = StMul;
                end else begin
                    // Last exponent bit is 0: the square is the final result.
                    out_data_d  = mult;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StMul: begin
                acc_d   = mult;
                step_d  = step_q - 3'd1;
                state_d = StSqr;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= 8'h00;
            opnd_q      <= 8'h00;
            step_q      <= 3'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            step_q      <= step_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StSqr) || (state_q == StMul);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_gf_inv_seq.sv
// Self-checking bench for gf_inv_seq: directed vectors, exhaustive sweep, backpressure,
// mid-operation reset and input-stability scenarios, with a scoreboard on the output side.
module tb_gf_inv_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] sb[$];

    gf_inv_seq #(.POLY(8'h1B)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Carry-less product followed by long division by 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'd0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    // Scoreboard: operands captured on accept, result checked on output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) sb.push_back(in_data);
            if (out_valid && out_ready) begin
                check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    logic [7:0] a;
                    a = sb.pop_front();
                    if (a == 8'h00) check("inv_zero", 32'(out_data), 32'h00);
                    else check("inv_prod", 32'(ref_mul(a, out_data)), 32'h01);
                end
            end
        end
    end

    task automatic wait_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (out_valid) break;
            wait_pos();
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            wait_pos();
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] exp);
        int edges;
        int busy_cnt;
        wait_pos();
        in_valid  = 1'b1;
        in_data   = a;
        out_ready = 1'b1;
        check("vec_in_ready", 32'(in_ready), 32'd1);
        wait_pos();
        in_valid = 1'b0;
        edges    = 0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) break;
            busy_cnt += int'(busy);
            wait_pos();
            edges++;
        end
        check("vec_latency", 32'(edges), 32'd13);
        check("vec_busy_cycles", 32'(busy_cnt), 32'd13);
        check("vec_data", 32'(out_data), 32'(exp));
        wait_pos();
        check("vec_ov_cleared", 32'(out_valid), 32'd0);
        check("vec_ready_again", 32'(in_ready), 32'd1);
        check("vec_busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        int last_acc;
        int accepted;
        int ov_seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset and idle
        wait_pos();
        wait_pos();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_pos();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Known vectors
        run_one(8'h53, 8'hCA);
        run_one(8'hCA, 8'h53);
        run_one(8'h02, 8'h8D);
        run_one(8'h01, 8'h01);
        run_one(8'h00, 8'h00);

        // Exhaustive sweep with in_valid and out_ready held high
        wait_pos();
        out_ready = 1'b1;
        in_data   = 8'h01;
        in_valid  = 1'b1;
        a         = 1;
        last_acc  = -1;
        accepted  = 0;
        for (int k = 0; k < 5000; k++) begin
            if (in_ready && in_valid) begin
                if (last_acc >= 0) check("tput_spacing", 32'(cyc - last_acc), 32'd15);
                last_acc = cyc;
                accepted = 1;
            end
            wait_pos();
            if (accepted != 0) begin
                accepted = 0;
                a++;
                if (a > 255) break;
                in_data = 8'(a);
            end
        end
        in_valid = 1'b0;
        check("exh_count", 32'(a), 32'd256);
        drain();

        // Backpressure
        wait_pos();
        in_valid  = 1'b1;
        in_data   = 8'h53;
        out_ready = 1'b0;
        wait_pos();
        in_valid = 1'b0;
        wait_valid("bp_valid");
        in_valid = 1'b1;
        in_data  = 8'h02;
        for (int k = 0; k < 20; k++) begin
            wait_pos();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'hCA);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        wait_pos();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        wait_pos();
        check("bp_next_accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_valid("bp_next_valid");
        check("bp_next_data", 32'(out_data), 32'h8D);
        drain();

        // Reset mid-operation
        wait_pos();
        in_valid  = 1'b1;
        in_data   = 8'h53;
        out_ready = 1'b1;
        wait_pos();
        in_valid = 1'b0;
        repeat (5) wait_pos();
        rst = 1'b1;
        wait_pos();
        rst = 1'b0;
        sb.delete();
        check("midrst_busy", 32'(busy), 32'd0);
        ov_seen = 0;
        for (int k = 0; k < 20; k++) begin
            ov_seen += int'(out_valid);
            wait_pos();
        end
        check("midrst_no_pulse", 32'(ov_seen), 32'd0);
        run_one(8'h02, 8'h8D);

        // Input stability: in_data changes after accept must not matter
        wait_pos();
        in_valid  = 1'b1;
        in_data   = 8'h53;
        out_ready = 1'b1;
        wait_pos();
        in_data = 8'hFF;
        wait_valid("stab_valid");
        check("stab_data", 32'(out_data), 32'hCA);
        check("stab_ready_low", 32'(in_ready), 32'd0);
        wait_pos();
        check("stab_ov_cleared", 32'(out_valid), 32'd0);
        check("stab_ready_high", 32'(in_ready), 32'd1);
        check("stab_not_busy", 32'(busy), 32'd0);
        wait_pos();
        check("stab_ff_accepted", 32'(busy), 32'd1);
        in_valid = 1'b0;
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
